cas_fsk_player: RTL and testbench



---
 rtl/cas_pkg.sv | 31 +++
 rtl/fsk_half_timer.sv | 28 ++
 rtl/cas_fsk_player.sv | 175 +++++++++++++++++
 tb/tb_cas_fsk_player.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cas_pkg.sv
// Shared types and constants for the cassette FSK playback block.
package cas_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    HI,
    LO,
    DONE
  } cas_state_t;

  // Default half-cycle lengths at 57.272 MHz: 1200 Hz for a 0 bit, 2400 Hz for a 1 bit.
  localparam int DEF_HALF_0 = 23863;
  localparam int DEF_HALF_1 = 11932;

  // Coinciding events, listed in decreasing priority.
  typedef enum logic [1:0] {
    EV_LOAD,
    EV_REWIND,
    EV_FREEZE,
    EV_ADVANCE
  } cas_event_t;

  function automatic int cnt_width(input int h0, input int h1);
    int m;
    m = (h0 > h1) ? h0 : h1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/fsk_half_timer.sv
// Half-cycle down-counter: pulses half_done on the last cycle of a half period.
module fsk_half_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             run,
  input  logic [CNT_W-1:0] half,
  output logic             half_done
);

  logic [CNT_W-1:0] cnt_reg;

  // The count simply holds while run is low, which is what freezes playback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (start) begin
      cnt_reg <= half - CNT_W'(1);
    end else if (run && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign half_done = run && (cnt_reg == '0);

endmodule

// File: rtl/cas_fsk_player.sv
// Plays a downloaded .cas image out of byte RAM as a 1200/2400 Hz FSK square wave.
module cas_fsk_player
  import cas_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int HALF_0 = DEF_HALF_0,
  parameter int HALF_1 = DEF_HALF_1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              load_wr,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              motor,
  input  logic              rewind,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              casdout,
  output logic              playing,
  output logic              eof,
  output logic [ADDR_W-1:0] pos
);

  localparam int CNT_W = cnt_width(HALF_0, HALF_1);

  cas_state_t state_reg, state_next;
  cas_event_t evt;

  logic              load_q_reg;
  logic              load_rise;
  logic [ADDR_W:0]   len_reg, len_base, wr_end, pos_inc;
  logic [ADDR_W-1:0] pos_reg;
  logic [7:0]        shreg_reg, hold_reg;
  logic [2:0]        bit_idx_reg;
  logic              pf_pending_reg, pf_capture_reg;
  logic              tmr_start, tmr_run, half_done;
  logic [CNT_W-1:0]  tmr_half;
  logic              do_latch, do_bit, do_byte, do_pf;

  function automatic logic [CNT_W-1:0] half_of(input logic b);
    return b ? CNT_W'(HALF_1) : CNT_W'(HALF_0);
  endfunction

  assign load_rise = load && !load_q_reg;
  assign pos_inc   = {1'b0, pos_reg} + {{ADDR_W{1'b0}}, 1'b1};
  // ADDR_W+1 bits: the largest address yields exactly 2^ADDR_W, so no extra clamp is needed.
  assign wr_end    = {1'b0, load_addr} + {{ADDR_W{1'b0}}, 1'b1};
  assign len_base  = load_rise ? '0 : len_reg;

  always_comb begin
    if (load)        evt = EV_LOAD;
    else if (rewind) evt = EV_REWIND;
    else if (!motor) evt = EV_FREEZE;
    else             evt = EV_ADVANCE;
  end

  assign tmr_run = (evt == EV_ADVANCE) && ((state_reg == HI) || (state_reg == LO));

  fsk_half_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .start     (tmr_start),
    .run       (tmr_run),
    .half      (tmr_half),
    .half_done (half_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    tmr_start  = 1'b0;
    tmr_half   = half_of(shreg_reg[0]);
    do_latch   = 1'b0;
    do_bit     = 1'b0;
    do_byte    = 1'b0;
    do_pf      = 1'b0;
    if ((evt == EV_LOAD) || (evt == EV_REWIND)) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if ({1'b0, pos_reg} >= len_reg) state_next = DONE;
          else if (evt == EV_ADVANCE)     state_next = FETCH;
        end
        FETCH: state_next = LATCH;
        LATCH: begin
          do_latch   = 1'b1;
          tmr_start  = 1'b1;
          tmr_half   = half_of(rd_data[0]);
          state_next = HI;
        end
        HI: begin
          if (half_done) begin
            tmr_start  = 1'b1;
            state_next = LO;
          end
        end
        LO: begin
          if (half_done) begin
            if (bit_idx_reg != 3'd7) begin
              do_bit     = 1'b1;
              tmr_start  = 1'b1;
              tmr_half   = half_of(shreg_reg[1]);
              state_next = HI;
              // Entering bit 7: fetch the next byte now so it is ready with no gap.
              do_pf      = (bit_idx_reg == 3'd6) && (pos_inc < len_reg);
            end else if (pos_inc == len_reg) begin
              state_next = DONE;
            end else begin
              do_byte    = 1'b1;
              tmr_start  = 1'b1;
              tmr_half   = half_of(hold_reg[0]);
              state_next = HI;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_q_reg     <= 1'b0;
      len_reg        <= '0;
      pos_reg        <= '0;
      shreg_reg      <= '0;
      hold_reg       <= '0;
      bit_idx_reg    <= '0;
      pf_pending_reg <= 1'b0;
      pf_capture_reg <= 1'b0;
    end else begin
      load_q_reg     <= load;
      pf_pending_reg <= do_pf;
      pf_capture_reg <= pf_pending_reg;
      if (pf_capture_reg) hold_reg <= rd_data;
      if (load_wr && (wr_end > len_base)) len_reg <= wr_end;
      else                                len_reg <= len_base;
      if (load_rise || rewind) begin
        pos_reg        <= '0;
        pf_pending_reg <= 1'b0;
        pf_capture_reg <= 1'b0;
      end else begin
        if (do_latch) begin
          shreg_reg   <= rd_data;
          bit_idx_reg <= 3'd0;
        end
        if (do_bit) begin
          shreg_reg   <= shreg_reg >> 1;
          bit_idx_reg <= bit_idx_reg + 3'd1;
        end
        if (do_byte) begin
          shreg_reg   <= hold_reg;
          bit_idx_reg <= 3'd0;
          pos_reg     <= pos_inc[ADDR_W-1:0];
        end
      end
    end
  end

  assign rd_en   = !load && ((state_reg == FETCH) || pf_pending_reg);
  assign rd_addr = pf_pending_reg ? pos_inc[ADDR_W-1:0] : pos_reg;
  assign casdout = (state_reg == HI);
  assign playing = motor && ((state_reg == HI) || (state_reg == LO));
  assign eof     = (state_reg == DONE);
  assign pos     = pos_reg;

endmodule

// File: tb/tb_cas_fsk_player.sv
// Self-checking bench: per-cycle waveform model plus table, random and corner-case sequences.
module tb_cas_fsk_player;

  localparam int PH_IDLE = 0, PH_F1 = 1, PH_F2 = 2, PH_PLAY = 3, PH_DONE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic        load_wr = 1'b0;
  logic [15:0] load_addr = '0;
  logic        motor = 1'b0;
  logic        rewind = 1'b0;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data = '0;
  logic        casdout, playing, eof;
  logic [15:0] pos;

  cas_fsk_player #(.ADDR_W(16), .HALF_0(8), .HALF_1(4)) dut (
    .clk(clk), .reset(reset), .load(load), .load_wr(load_wr), .load_addr(load_addr),
    .motor(motor), .rewind(rewind), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .casdout(casdout), .playing(playing), .eof(eof), .pos(pos)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  int rd_total = 0;
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data  <= mem[rd_addr];
      rd_total <= rd_total + 1;
    end
  end

  int total = 0;
  int bad = 0;

  // Reference model: the whole image expanded into one casdout value per playing cycle.
  int m_len = 0, m_idx = 0, m_pos = 0, m_phase = PH_IDLE;
  bit m_load_q = 1'b0;
  bit wave[$];
  int wave_byte[$];

  typedef struct {
    int               n;
    logic [3:0][7:0]  d;
    int               gap_at;
    int               gap_len;
    int               exp_eof;
    int               exp_pos;
    int               exp_rd;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build_wave();
    wave.delete();
    wave_byte.delete();
    for (int b = 0; b < m_len; b++) begin
      for (int k = 0; k < 8; k++) begin
        int h;
        h = mem[b][k] ? 4 : 8;
        for (int c = 0; c < 2 * h; c++) begin
          wave.push_back(c < h);
          wave_byte.push_back(b);
        end
      end
    end
  endtask

  function automatic int image_cycles(input int n);
    int s;
    s = 0;
    for (int b = 0; b < n; b++)
      for (int k = 0; k < 8; k++)
        s += mem[b][k] ? 8 : 16;
    return s;
  endfunction

  task automatic model_edge();
    if (load && !m_load_q) begin
      m_len = 0;
      m_pos = 0;
    end
    if (load_wr && (int'(load_addr) + 1 > m_len)) m_len = int'(load_addr) + 1;
    m_load_q = load;
    if (load) begin
      m_phase = PH_IDLE;
    end else if (rewind) begin
      m_phase = PH_IDLE;
      m_pos   = 0;
    end else begin
      case (m_phase)
        PH_IDLE: if (m_pos >= m_len) m_phase = PH_DONE; else if (motor) m_phase = PH_F1;
        PH_F1: begin build_wave(); m_phase = PH_F2; end
        PH_F2: begin m_phase = PH_PLAY; m_idx = 0; m_pos = 0; end
        PH_PLAY: if (motor) begin
          m_idx++;
          if (m_idx >= wave.size()) m_phase = PH_DONE;
          else m_pos = wave_byte[m_idx];
        end
        default: ;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("casdout", casdout, (m_phase == PH_PLAY) ? int'(wave[m_idx]) : 0);
    chk("eof", eof, (m_phase == PH_DONE) ? 1 : 0);
    chk("playing", playing, (motor && m_phase == PH_PLAY) ? 1 : 0);
    chk("pos", pos, m_pos);
    if (load) chk("rd_en_during_load", rd_en, 0);
  endtask

  task automatic begin_load();
    load = 1'b1;
    step();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    load_wr   = 1'b1;
    load_addr = a;
    mem[a]    = d;
    step();
    load_wr   = 1'b0;
  endtask

  task automatic end_load();
    load_wr = 1'b0;
    load    = 1'b0;
    step();
  endtask

  task automatic load_image(input int n, input logic [3:0][7:0] d);
    begin_load();
    for (int i = 0; i < n; i++) wr(16'(i), d[i]);
    end_load();
  endtask

  // t=0 is the edge that first samples motor=1; motor is low for gap_len edges after edge gap_at.
  task automatic run_play(input int gap_at, input int gap_len, output int eof_t, output int rd_n);
    int base;
    base  = rd_total;
    eof_t = -1;
    motor = 1'b1;
    for (int t = 0; t < 3000 && eof_t < 0; t++) begin
      step();
      if (eof) eof_t = t;
      if (t == gap_at && gap_len > 0) motor = 1'b0;
      if (t == gap_at + gap_len) motor = 1'b1;
    end
    motor = 1'b0;
    rd_n  = rd_total - base;
  endtask

  initial begin
    int eof_t, rd_n, n, ga, gl, base;
    logic [3:0][7:0] d;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    // 0x01,0x80: each byte = one 1-bit (8) + seven 0-bits (112) = 120 cycles, plus 2 start cycles.
    tbl[0] = '{2, 32'h0000_8001, 0, 0, 242, 1, 2};
    tbl[1] = '{1, 32'h0000_00FF, 7, 20, 86, 0, 1};
    tbl[2] = '{1, 32'h0000_0000, 0, 0, 130, 0, 1};
    tbl[3] = '{2, 32'h0000_3CA5, 0, 0, 194, 1, 2};
    tbl[4] = '{3, 32'h000F_00FF, 50, 5, 295, 2, 3};

    #3;
    chk("reset_casdout", casdout, 0);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_playing", playing, 0);
    chk("reset_eof", eof, 0);
    chk("reset_pos", pos, 0);
    @(negedge clk);
    reset = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      load_image(tbl[i].n, tbl[i].d);
      run_play(tbl[i].gap_at, tbl[i].gap_len, eof_t, rd_n);
      chk("tbl_eof_cycle", eof_t, tbl[i].exp_eof);
      chk("tbl_final_pos", pos, tbl[i].exp_pos);
      chk("tbl_rd_count", rd_n, tbl[i].exp_rd);
      $display("vec %0d: bytes=%0d data=%h eof_at=%0d pos=%0d reads=%0d", i, tbl[i].n, tbl[i].d, eof_t, pos, rd_n);
    end

    for (int r = 0; r < 6; r++) begin
      n  = int'($urandom_range(1, 4));
      d  = $urandom;
      ga = int'($urandom_range(2, 60));
      gl = int'($urandom_range(0, 30));
      load_image(n, d);
      run_play(ga, gl, eof_t, rd_n);
      chk("rand_eof_cycle", eof_t, 2 + image_cycles(n) + gl);
      chk("rand_final_pos", pos, n - 1);
      chk("rand_rd_count", rd_n, n);
      $display("rand %0d: bytes=%0d data=%h gap=%0d+%0d eof_at=%0d reads=%0d", r, n, d, ga, gl, eof_t, rd_n);
    end

    begin_load();
    wr(16'd5, 8'($urandom));
    wr(16'd2, 8'($urandom));
    wr(16'd9, 8'($urandom));
    end_load();
    chk("len_capture", int'(dut.len_reg), 10);
    run_play(0, 0, eof_t, rd_n);
    chk("len10_eof_cycle", eof_t, 2 + image_cycles(10));
    chk("len10_final_pos", pos, 9);
    chk("len10_rd_count", rd_n, 10);
    $display("len: writes 5,2,9 len=%0d eof_at=%0d pos=%0d", dut.len_reg, eof_t, pos);

    begin_load();
    wr(16'hFFFF, 8'h55);
    wr(16'd3, 8'h11);
    end_load();
    chk("len_saturate", int'(dut.len_reg), 65536);
    $display("len: writes FFFF,3 len=%0d", dut.len_reg);

    begin_load();
    end_load();
    motor = 1'b1;
    base  = rd_total;
    step();
    chk("zero_len_eof", eof, 1);
    repeat (8) step();
    chk("zero_len_no_read", rd_total - base, 0);
    motor = 1'b0;
    $display("zero-length: eof=%0d reads=%0d", eof, rd_total - base);

    load_image(2, 32'h0000_8001);
    motor = 1'b1;
    for (int t = 0; t < 150; t++) step();
    chk("pre_rewind_pos", pos, 1);
    rewind = 1'b1;
    step();
    rewind = 1'b0;
    chk("rewind_casdout", casdout, 0);
    chk("rewind_pos", pos, 0);
    step();
    step();
    chk("restart_gap", casdout, 0);
    step();
    chk("restart_first_bit", casdout, 1);
    for (int t = 0; t < 400 && !eof; t++) step();
    chk("rewind_then_eof", eof, 1);
    motor = 1'b0;
    $display("rewind: replay finished eof=%0d pos=%0d", eof, pos);

    load_image(2, 32'h0000_8001);
    motor = 1'b1;
    for (int t = 0; t < 126; t++) step();
    chk("pre_reset_casdout", casdout, 1);
    chk("pre_reset_pos", pos, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_casdout", casdout, 0);
    chk("async_playing", playing, 0);
    chk("async_eof", eof, 0);
    chk("async_rd_en", rd_en, 0);
    chk("async_rd_addr", rd_addr, 0);
    chk("async_pos", pos, 0);
    chk("async_len", int'(dut.len_reg), 0);
    $display("async reset: casdout=%0d pos=%0d len=%0d", casdout, pos, dut.len_reg);
    motor    = 1'b0;
    m_phase  = PH_IDLE;
    m_len    = 0;
    m_idx    = 0;
    m_pos    = 0;
    m_load_q = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("post_reset_eof", eof, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
